// File: rtl/game_pkg.sv
// Shared encodings for the memory-game front end.
// FSM states and small helpers used by player_input_capture.
package game_pkg;

  localparam logic [1:0] S_Idle    = 2'd0;
  localparam logic [1:0] S_PressDb = 2'd1;
  localparam logic [1:0] S_Held    = 2'd2;
  localparam logic [1:0] S_RelDb   = 2'd3;

  localparam logic [4:0] PRESS_MAX = 5'd31;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == PRESS_MAX) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous board inputs.
// Reset loads RST_VAL into both stages.
module sync2 #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/player_input_capture.sv
// Debounced push-button capture producing one p_button pulse per press,
// with the switch digit latched on p_input at the accepted press.
module player_input_capture
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       button_n,
  input  logic [3:0] sw_in,
  input  logic       arm,
  output logic       p_button,
  output logic [3:0] p_input,
  output logic [4:0] press_cnt,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       btn_s;
  logic [3:0] sw_s;

  sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_btn (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .d_i    (button_n),
    .q_o    (btn_s)
  );

  sync2 #(.W(4), .RST_VAL(4'h0)) u_sync_sw (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .d_i    (sw_in),
    .q_o    (sw_s)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pb_q, pb_d;
  logic [3:0]       pin_q, pin_d;
  logic [4:0]       pcnt_q, pcnt_d;
  logic             commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      S_Idle: begin
        if (!btn_s) begin
          state_d = S_PressDb;
          cnt_d   = '0;
        end
      end
      S_PressDb: begin
        if (btn_s) begin
          state_d = S_Idle;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_Held;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_Held: begin
        if (btn_s) begin
          state_d = S_RelDb;
          cnt_d   = '0;
        end
      end
      S_RelDb: begin
        if (!btn_s) begin
          state_d = S_Held;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_Idle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  // Pulse is rebuilt every cycle so it can only be high on the commit edge.
  always_comb begin
    pb_d   = 1'b0;
    pin_d  = pin_q;
    pcnt_d = pcnt_q;
    if (commit) begin
      pin_d = sw_s;
      if (arm) begin
        pb_d   = 1'b1;
        pcnt_d = sat_inc5(pcnt_q);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_Idle;
      cnt_q   <= '0;
      pb_q    <= 1'b0;
      pin_q   <= 4'h0;
      pcnt_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pb_q    <= pb_d;
      pin_q   <= pin_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign p_button  = pb_q;
  assign p_input   = pin_q;
  assign press_cnt = pcnt_q;
  assign busy      = (state_q != S_Idle);

endmodule

// File: tb/tb_player_input_capture.sv
// Self-checking bench for player_input_capture.
// Run-length press model plus directed literal checks.
module tb_player_input_capture;

  localparam int D = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       button_n = 1'b1;
  logic [3:0] sw_in = 4'h0;
  logic       arm = 1'b1;
  logic       p_button;
  logic [3:0] p_input;
  logic [4:0] press_cnt;
  logic       busy;

  player_input_capture #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .button_n  (button_n),
    .sw_in     (sw_in),
    .arm       (arm),
    .p_button  (p_button),
    .p_input   (p_input),
    .press_cnt (press_cnt),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit mon_en = 1'b0;

  // model: 2-deep delay lines, then run lengths of the synced button
  logic       mb1 = 1'b1, mb2 = 1'b1;
  logic [3:0] ms1 = 4'h0, ms2 = 4'h0;
  bit         ready = 1'b1;
  int         low_run = 0, high_run = 0;
  logic       m_pb = 1'b0;
  logic [3:0] m_pin = 4'h0;
  int         m_cnt = 0;
  logic       m_busy;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      if (!Rst) begin
        mb1 = 1'b1; mb2 = 1'b1;
        ms1 = 4'h0; ms2 = 4'h0;
        ready = 1'b1;
        low_run = 0; high_run = 0;
        m_pb = 1'b0; m_pin = 4'h0; m_cnt = 0;
      end else begin
        logic       bs;
        logic [3:0] ss;
        bs = mb2;
        ss = ms2;
        mb2 = mb1; mb1 = button_n;
        ms2 = ms1; ms1 = sw_in;
        m_pb = 1'b0;
        if (!bs) begin
          low_run++;
          high_run = 0;
        end else begin
          high_run++;
          low_run = 0;
        end
        if (ready && low_run == D + 1) begin
          ready = 1'b0;
          m_pin = ss;
          if (arm) begin
            m_pb = 1'b1;
            if (m_cnt < 31) m_cnt++;
          end
        end else if (!ready && high_run == D + 1) begin
          ready = 1'b1;
        end
      end
    end
  end

  assign m_busy = !ready || (low_run > 0);

  initial begin
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        chk("m_p_button", p_button, m_pb);
        chk("m_p_input", p_input, m_pin);
        chk("m_press_cnt", press_cnt, m_cnt);
        chk("m_busy", busy, m_busy);
        if (p_button === 1'b1) pulses++;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input int n, input logic [3:0] s);
    sw_in = s;
    button_n = 1'b0;
    repeat (n) tick();
    button_n = 1'b1;
    repeat (15) tick();
  endtask

  int p0;

  initial begin
    Rst = 1'b0;
    repeat (2) tick();
    mon_en = 1'b1;
    chk("rst_p_button", p_button, 0);
    chk("rst_p_input", p_input, 0);
    chk("rst_press_cnt", press_cnt, 0);
    chk("rst_busy", busy, 0);
    Rst = 1'b1;
    repeat (3) tick();

    // glitch
    button_n = 1'b0;
    repeat (3) tick();
    button_n = 1'b1;
    repeat (15) tick();
    chk("glitch_press_cnt", press_cnt, 0);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_busy", busy, 0);

    // clean press, latency D+3 = 7
    sw_in = 4'hA;
    button_n = 1'b0;
    repeat (6) tick();
    chk("clean_edge6", p_button, 0);
    tick();
    chk("clean_edge7", p_button, 1);
    chk("clean_p_input", p_input, 4'hA);
    chk("clean_press_cnt", press_cnt, 1);
    tick();
    chk("clean_edge8", p_button, 0);
    repeat (12) tick();
    button_n = 1'b1;
    repeat (15) tick();
    chk("clean_pulses", pulses, 1);

    // bounce
    p0 = pulses;
    button_n = 1'b0; repeat (10) tick();
    button_n = 1'b1; repeat (2) tick();
    button_n = 1'b0; repeat (10) tick();
    button_n = 1'b1; repeat (20) tick();
    chk("bounce_pulses", pulses - p0, 1);
    chk("bounce_press_cnt", press_cnt, 2);

    // switch isolation
    sw_in = 4'h3;
    button_n = 1'b0;
    repeat (10) tick();
    chk("iso_commit", p_input, 4'h3);
    sw_in = 4'h9;
    repeat (5) tick();
    chk("iso_held", p_input, 4'h3);
    button_n = 1'b1;
    repeat (15) tick();
    chk("iso_idle", p_input, 4'h3);
    press(10, 4'h9);
    chk("iso_next", p_input, 4'h9);
    chk("iso_press_cnt", press_cnt, 4);

    // disarmed press
    arm = 1'b0;
    p0 = pulses;
    press(10, 4'h5);
    chk("arm0_pulses", pulses - p0, 0);
    chk("arm0_press_cnt", press_cnt, 4);
    chk("arm0_p_input", p_input, 4'h5);
    arm = 1'b1;

    // reset during press debounce
    sw_in = 4'h7;
    button_n = 1'b0;
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    Rst = 1'b0;
    button_n = 1'b1;
    tick();
    Rst = 1'b1;
    chk("mid_p_button", p_button, 0);
    chk("mid_p_input", p_input, 0);
    chk("mid_press_cnt", press_cnt, 0);
    chk("mid_busy0", busy, 0);
    p0 = pulses;
    repeat (15) tick();
    chk("mid_pulses", pulses - p0, 0);

    // saturation
    for (int i = 0; i < 33; i++) begin
      logic [31:0] iv;
      iv = i;
      press(10, iv[3:0]);
    end
    chk("sat_press_cnt", press_cnt, 31);
    chk("sat_p_input", p_input, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
